// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions, divider states and flag helpers.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_DIV
   } AluOp;

   localparam int unsigned ALU_FLAG_Z = 0;
   localparam int unsigned ALU_FLAG_C = 1;
   localparam int unsigned ALU_FLAG_V = 2;
   localparam int unsigned ALU_FLAG_S = 3;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // V and S set: quotient does not fit, or divisor is zero
   localparam logic [3:0] DIV_OVF_FLAGS = 4'b1100;

   function automatic logic [3:0] div_flags(input logic [7:0] quot);
      logic [3:0] f;
      f             = '0;
      f[ALU_FLAG_Z] = (quot == 8'h00);
      f[ALU_FLAG_S] = quot[7];
      return f;
   endfunction

endpackage

// File: rtl/alu_divider_if.sv
// Issue/result bundle between the microcode sequencer (master) and the divider (slave).
interface alu_divider_if;

   logic        start;
   logic [15:0] A;
   logic [7:0]  B;
   logic        busy;
   logic        done;
   logic [15:0] R;
   logic [3:0]  flags;
   logic        div_zero;

   modport master (
      output start, A, B,
      input  busy, done, R, flags, div_zero
   );

   modport slave (
      input  start, A, B,
      output busy, done, R, flags, div_zero
   );

endinterface

// File: rtl/alu_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step (
   input  logic [7:0] i_rem,
   input  logic       i_qbit,
   input  logic [7:0] i_b,
   output logic [7:0] o_rem,
   output logic       o_q
);

   logic [8:0] w_t;

   assign w_t   = {i_rem, i_qbit};
   assign o_q   = (w_t >= {1'b0, i_b});
   // On success t - B < B, so the low 8 bits of the modulo-256 difference are exact
   assign o_rem = o_q ? (w_t[7:0] - i_b) : w_t[7:0];

endmodule

// File: rtl/alu_divider.sv
// Sequential 16/8 unsigned restoring divider for DIV; ALU_DIVIDER_RADIX4_EN chains two steps per cycle.
module alu_divider
   import alu_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   alu_divider_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = DIV_IDLE;
   localparam logic [1:0] ST_CALC = DIV_CALC;
   localparam logic [1:0] ST_DONE = DIV_DONE;

`ifdef ALU_DIVIDER_RADIX4_EN
   localparam logic [2:0] LAST_ITER = 3'd3;
`else
   localparam logic [2:0] LAST_ITER = 3'd7;
`endif

   logic [1:0]  r_state;
   logic [7:0]  r_b;
   logic [7:0]  r_rem;
   logic [7:0]  r_q;
   logic [2:0]  r_cnt;
   logic        r_busy;
   logic        r_done;
   logic [15:0] r_r;
   logic [3:0]  r_flags;
   logic        r_div_zero;

   logic [7:0]  w_rem1;
   logic        w_q1;
   logic [7:0]  w_rem_next;
   logic [7:0]  w_q_next;

   div_step u_step0 (
      .i_rem  (r_rem),
      .i_qbit (r_q[7]),
      .i_b    (r_b),
      .o_rem  (w_rem1),
      .o_q    (w_q1)
   );

`ifdef ALU_DIVIDER_RADIX4_EN
   logic [7:0] w_rem2;
   logic       w_q2;

   div_step u_step1 (
      .i_rem  (w_rem1),
      .i_qbit (r_q[6]),
      .i_b    (r_b),
      .o_rem  (w_rem2),
      .o_q    (w_q2)
   );

   assign w_rem_next = w_rem2;
   assign w_q_next   = {r_q[5:0], w_q1, w_q2};
`else
   assign w_rem_next = w_rem1;
   assign w_q_next   = {r_q[6:0], w_q1};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_b        <= '0;
         r_rem      <= '0;
         r_q        <= '0;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_r        <= '0;
         r_flags    <= '0;
         r_div_zero <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == ST_CALC) begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == LAST_ITER) begin
               r_r     <= {w_rem_next, w_q_next};
               r_flags <= div_flags(w_q_next);
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end
         end else if (bus.start) begin
            // The DONE cycle doubles as an issue slot so back-to-back divides lose no cycle
            r_b        <= bus.B;
            r_busy     <= 1'b1;
            r_div_zero <= 1'b0;
            if (bus.B == 8'h00) begin
               r_r        <= bus.A;
               r_flags    <= DIV_OVF_FLAGS;
               r_div_zero <= 1'b1;
               r_done     <= 1'b1;
               r_state    <= ST_DONE;
            end else if (bus.A[15:8] >= bus.B) begin
               r_r     <= bus.A;
               r_flags <= DIV_OVF_FLAGS;
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end else begin
               r_rem   <= bus.A[15:8];
               r_q     <= bus.A[7:0];
               r_cnt   <= '0;
               r_state <= ST_CALC;
            end
         end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
         end
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.R        = r_r;
   assign bus.flags    = r_flags;
   assign bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_alu_divider.sv
// Directed self-checking bench for alu_divider; honours ALU_DIVIDER_RADIX4_EN for latency.
module tb_alu_divider;

`ifdef ALU_DIVIDER_RADIX4_EN
   localparam int NLAT = 4;
`else
   localparam int NLAT = 8;
`endif

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   alu_divider_if bus ();

   alu_divider dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one divide from idle, find done, check result, pulse width and return to idle.
   task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] er, input logic [3:0] ef, input logic edz,
                          input int elat);
      int lat;
      bit seen;
      logic [15:0] r_seen;
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      tick();
      bus.start = 1'b0;
      bus.A     = ~a;
      bus.B     = ~b;
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 24 && !seen; i++) begin
         if (bus.done) seen = 1'b1;
         else begin
            tick();
            lat++;
         end
      end
      check_eq({tag, "_latency"}, lat, elat);
      check_eq({tag, "_R"}, bus.R, er);
      check_eq({tag, "_flags"}, bus.flags, ef);
      check_eq({tag, "_divzero"}, bus.div_zero, edz);
      check_eq({tag, "_busy_at_done"}, bus.busy, 1'b1);
      r_seen = bus.R;
      tick();
      check_eq({tag, "_done_pulse"}, bus.done, 1'b0);
      check_eq({tag, "_busy_after"}, bus.busy, 1'b0);
      check_eq({tag, "_R_held"}, bus.R, r_seen);
   endtask

   initial begin
      int          ndone;
      int          k1;
      int          k2;
      logic [15:0] r1;
      logic [15:0] r2;
      logic [3:0]  f2;

      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.A     = 16'h0;
      bus.B     = 8'h0;
      tick();
      tick();
      reset = 1'b0;
      check_eq("rst_busy", bus.busy, 1'b0);
      check_eq("rst_done", bus.done, 1'b0);
      check_eq("rst_R", bus.R, 16'h0000);
      check_eq("rst_flags", bus.flags, 4'h0);
      check_eq("rst_divzero", bus.div_zero, 1'b0);

      run_div("t1", 16'h0064, 8'h07, 16'h020E, 4'b0000, 1'b0, NLAT);
      run_div("t2_ovf", 16'h1234, 8'h10, 16'h1234, 4'b1100, 1'b0, 0);
      run_div("t3_dz", 16'hBEEF, 8'h00, 16'hBEEF, 4'b1100, 1'b1, 0);
      run_div("t3_clear", 16'h0064, 8'h07, 16'h020E, 4'b0000, 1'b0, NLAT);
      run_div("t4_q0", 16'h0005, 8'h09, 16'h0500, 4'b0001, 1'b0, NLAT);
      run_div("t4_q80", 16'h0100, 8'h02, 16'h0080, 4'b1000, 1'b0, NLAT);
      run_div("t4_qff", 16'hFEFF, 8'hFF, 16'hFEFF, 4'b1000, 1'b0, NLAT);
      run_div("t4_hi_eq", 16'h0700, 8'h07, 16'h0700, 4'b1100, 1'b0, 0);
      run_div("t4_max", 16'h06FF, 8'h07, 16'h06FF, 4'b1000, 1'b0, NLAT);

      // Start at N+3 must be ignored; start at N+9 is accepted with its own operands
      bus.start = 1'b1;
      bus.A     = 16'h0064;
      bus.B     = 8'h07;
      tick();
      ndone = 0;
      k1 = -1;
      k2 = -1;
      r1 = '0;
      r2 = '0;
      f2 = '0;
      for (int k = 1; k <= 9 + NLAT + 3; k++) begin
         bus.start = (k == 3) || (k == 9);
         bus.A     = (k == 3) ? 16'h0005 : 16'h0100;
         bus.B     = (k == 3) ? 8'h09 : 8'h02;
         tick();
         if (bus.done) begin
            ndone++;
            if (k1 < 0) begin
               k1 = k;
               r1 = bus.R;
            end else begin
               k2 = k;
               r2 = bus.R;
               f2 = bus.flags;
            end
         end
      end
      bus.start = 1'b0;
      check_eq("t5_ndone", ndone, 2);
      check_eq("t5_first_lat", k1, NLAT);
      check_eq("t5_first_R", r1, 16'h020E);
      check_eq("t5_second_lat", k2, 9 + NLAT);
      check_eq("t5_second_R", r2, 16'h0080);
      check_eq("t5_second_flags", f2, 4'b1000);

      // Reset at N+4 aborts the divide
      bus.start = 1'b1;
      bus.A     = 16'h0064;
      bus.B     = 8'h07;
      tick();
      bus.start = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 15; k++) begin
         reset = (k == 4);
         tick();
         if (bus.done) ndone++;
         if (k == 4) begin
            check_eq("t6_busy", bus.busy, 1'b0);
            check_eq("t6_R", bus.R, 16'h0000);
            check_eq("t6_flags", bus.flags, 4'h0);
            check_eq("t6_divzero", bus.div_zero, 1'b0);
         end
      end
      reset = 1'b0;
      check_eq("t6_no_done", ndone, 0);
      check_eq("t6_idle", bus.busy, 1'b0);
      run_div("t6_after", 16'h0005, 8'h09, 16'h0500, 4'b0001, 1'b0, NLAT);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
